// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM state codes and datapath widths shared by the MEM stage
package mem_stage_pkg;
   typedef enum logic [1:0] {MS_IDLE, MS_BUSY, MS_DONE} ms_state_t;
   localparam int DATA_W   = 16;
   localparam int RESULT_W = 32;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM-side request bus and MEM/WB-side result bus of the MEM stage
interface mem_stage_if;
   import mem_stage_pkg::*;
   logic                valid_in;
   logic                mem_read;
   logic                mem_write;
   logic                byte_op;
   logic [DATA_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [RESULT_W-1:0] alu_result_in;
   logic [15:0]         instruction_in;
   logic                stall;
   logic                valid_out;
   logic [RESULT_W-1:0] result_out;
   logic [15:0]         instruction_out;
   logic                misalign;
   modport master (
      output valid_in, mem_read, mem_write, byte_op, addr, wdata, alu_result_in, instruction_in,
      input  stall, valid_out, result_out, instruction_out, misalign
   );
   modport slave (
      input  valid_in, mem_read, mem_write, byte_op, addr, wdata, alu_result_in, instruction_in,
      output stall, valid_out, result_out, instruction_out, misalign
   );
endinterface

// File: rtl/mem_stage_dmem_ram.sv
// dmem_ram: two byte-lane arrays with per-lane write enables and a registered read port
module dmem_ram #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_lo,
   input  logic                  we_hi,
   input  logic                  re,
   input  logic                  rbyte,
   input  logic                  rclr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            din_lo,
   input  logic [7:0]            din_hi,
   output logic [15:0]           rdata_q
);
   localparam int WORDS = 2 ** (ADDR_WIDTH - 1);
   logic [7:0]            lo_mem [WORDS];
   logic [7:0]            hi_mem [WORDS];
   logic [ADDR_WIDTH-2:0] wa;
   logic [15:0]           rdata_d;
   assign wa = addr[ADDR_WIDTH-1:1];
   // Read data: cleared on a faulted access, one lane zero-extended for byte loads
   always_comb
      rdata_d = rclr  ? '0 :
                rbyte ? {8'h00, addr[0] ? hi_mem[wa] : lo_mem[wa]} :
                        {hi_mem[wa], lo_mem[wa]};
   // Lane writes; the arrays themselves are never reset
   always_ff @(posedge clk) begin
      if (we_lo) lo_mem[wa] <= din_lo;
      if (we_hi) hi_mem[wa] <= din_hi;
   end
   // Read register, loaded only at the access edge
   always_ff @(posedge clk or posedge rst)
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= rdata_d;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with wait-stated data RAM; byte access under DMEM_BYTE_ACCESS_EN
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);
   ms_state_t           state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                misalign_q, misalign_d, load_q, load_d;
   logic [RESULT_W-1:0] alu_q, alu_d;
   logic [15:0]         instr_q, instr_d;
   logic [DATA_W-1:0]   rdata_q;
   logic                mem_op, byte_eff, mis, access, wr, pass, done, unused_ok;
`ifdef DMEM_BYTE_ACCESS_EN
   assign byte_eff = bus.byte_op;
`else
   assign byte_eff = 1'b0;
`endif
   assign unused_ok = ^{bus.addr, bus.byte_op};
   assign mem_op    = bus.mem_read | bus.mem_write;
   assign mis       = !byte_eff & bus.addr[0];
   assign access    = (state_q == MS_BUSY) && (cnt_q == '0);
   assign wr        = access & bus.mem_write & !bus.mem_read & !mis;
   assign pass      = (state_q == MS_IDLE) & bus.valid_in & !mem_op;
   assign done      = (state_q == MS_DONE);

   dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_lo   (wr & !(byte_eff & bus.addr[0])),
      .we_hi   (wr & !(byte_eff & !bus.addr[0])),
      .re      (access),
      .rbyte   (byte_eff),
      .rclr    (mis),
      .addr    (bus.addr[ADDR_WIDTH-1:0]),
      .din_lo  (bus.wdata[7:0]),
      .din_hi  (byte_eff ? bus.wdata[7:0] : bus.wdata[15:8]),
      .rdata_q (rdata_q)
   );

   // Next state: accept in IDLE, count wait states, capture op context at the access edge
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      misalign_d = misalign_q;
      load_d     = load_q;
      alu_d      = alu_q;
      instr_d    = instr_q;
      case (state_q)
         MS_IDLE: if (bus.valid_in & mem_op) begin
            state_d = MS_BUSY;
            cnt_d   = 4'(WAIT_STATES);
         end
         MS_BUSY: if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
         else begin
            state_d    = MS_DONE;
            misalign_d = mis;
            load_d     = bus.mem_read;
            alu_d      = bus.alu_result_in;
            instr_d    = bus.instruction_in;
         end
         default: state_d = MS_IDLE;
      endcase
   end

   // Stage state registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= MS_IDLE;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
         load_q     <= 1'b0;
         alu_q      <= '0;
         instr_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         misalign_q <= misalign_d;
         load_q     <= load_d;
         alu_q      <= alu_d;
         instr_q    <= instr_d;
      end

   // Outputs: pass-through in IDLE, registered results in DONE, stall while an access is pending
   always_comb begin
      bus.stall           = ((state_q == MS_IDLE) & bus.valid_in & mem_op) | (state_q == MS_BUSY);
      bus.valid_out       = pass | done;
      bus.result_out      = done ? (load_q ? {{(RESULT_W-DATA_W){1'b0}}, rdata_q} : alu_q) :
                            pass ? bus.alu_result_in : '0;
      bus.instruction_out = done ? instr_q : bus.instruction_in;
      bus.misalign        = done & misalign_q;
   end
endmodule
